apb_master: RTL and testbench

APB bridge sitting between the RISC-V core's data-memory bus and the APB peripherals, with the GPIO peripheral on slot 1.
- Converts each single-cycle core request into one APB3 transfer (SETUP then ACCESS).
- Decodes the address to one of NUM_SLV PSEL lines.
- Muxes the selected slave's PRDATA/PREADY back to the core as a one-cycle completion pulse.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_addr_decoder.sv | 33 +++
 rtl/apb_master.sv | 189 ++++++++++++++++++
 tb/tb_apb_master.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB bridge.
//   apb_state_t     - bridge FSM state encoding (IDLE, SETUP, ACCESS)
//   APB_BASE_ADDR   - default start of the peripheral region
//   APB_SLV_SIZE    - address window of each slave (4 KB)
//   APB_NUM_SLV_DEF - default number of slaves
//   APB_TIMEOUT_DEF - default ACCESS-phase cycle limit
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam logic [31:0] APB_BASE_ADDR   = 32'h1000_0000;
  localparam logic [31:0] APB_SLV_SIZE    = 32'h0000_1000;
  localparam int          APB_NUM_SLV_DEF = 4;
  localparam int          APB_TIMEOUT_DEF = 16;

endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: combinational map from a core byte address to a one-hot
// slave select. Slave i owns BASE_ADDR + i*4KB .. BASE_ADDR + (i+1)*4KB - 1.
// Ports:
//   addr_i [31:0]        core byte address
//   sel_o  [NUM_SLV-1:0] one-hot select, all zero on a miss
//   hit_o                address falls inside the peripheral region
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLV   = APB_NUM_SLV_DEF,
  parameter logic [31:0] BASE_ADDR = APB_BASE_ADDR
) (
  input  logic [31:0]        addr_i,
  output logic [NUM_SLV-1:0] sel_o,
  output logic               hit_o
);

  localparam logic [31:0] REGION = 32'(NUM_SLV) * APB_SLV_SIZE;

  logic [31:0] offset;

  // Addresses below BASE_ADDR wrap to huge offsets, so one unsigned compare
  // covers both ends of the region.
  always_comb begin
    offset = addr_i - BASE_ADDR;
    hit_o  = (offset < REGION);
    sel_o  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel_o[i] = hit_o && (offset[14:12] == 3'(i));
    end
  end

endmodule

// File: rtl/apb_master.sv
// apb_master: bridge from single-cycle core requests to APB3 transfers.
// Each accepted request runs SETUP then ACCESS on the decoded slave and
// returns a one-cycle ready pulse with rdata/err. All outputs are registered.
// Optional feature macro: APB_MASTER_TIMEOUT_EN ends an ACCESS phase with
// err=1 after TIMEOUT_CYC cycles without PREADY from the selected slave.
// Ports:
//   PCLK, PRESET          clock, synchronous active-high reset
//   req, addr, wdata, we  core request (req is a one-cycle pulse)
//   rdata, ready, err     core completion (valid while ready=1)
//   PADDR, PWDATA, PWRITE APB address/data/direction (held in IDLE)
//   PENABLE, PSEL         APB access phase and one-hot slave select
//   PRDATA, PREADY        per-slave read data (32 bits each) and ready
module apb_master
  import apb_pkg::*;
#(
  parameter int          NUM_SLV     = APB_NUM_SLV_DEF,
  parameter logic [31:0] BASE_ADDR   = APB_BASE_ADDR,
  parameter int          TIMEOUT_CYC = APB_TIMEOUT_DEF
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  input  logic                  we,
  output logic [31:0]           rdata,
  output logic                  ready,
  output logic                  err,
  output logic [31:0]           PADDR,
  output logic [31:0]           PWDATA,
  output logic                  PWRITE,
  output logic                  PENABLE,
  output logic [NUM_SLV-1:0]    PSEL,
  input  logic [NUM_SLV*32-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]    PREADY
);

  if (NUM_SLV < 1 || NUM_SLV > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_param
    $error("apb_master: NUM_SLV must be 1..8 and TIMEOUT_CYC 1..255");
  end

  apb_state_t         state_q, state_d;
  logic [31:0]        paddr_q, paddr_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic               pwrite_q, pwrite_d;
  logic               penable_q, penable_d;
  logic [NUM_SLV-1:0] psel_q, psel_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;

  logic [NUM_SLV-1:0] dec_sel;
  logic               dec_hit;
  logic               rdy_sel;
  logic [31:0]        rd_sel;

`ifdef APB_MASTER_TIMEOUT_EN
  logic [7:0]         cnt_q, cnt_d;
`endif

  apb_addr_decoder #(
    .NUM_SLV  (NUM_SLV),
    .BASE_ADDR(BASE_ADDR)
  ) u_dec (
    .addr_i(addr),
    .sel_o (dec_sel),
    .hit_o (dec_hit)
  );

  // PSEL is only non-zero during SETUP/ACCESS, so it doubles as the latched
  // slave index for masking PREADY/PRDATA of the selected slave.
  always_comb begin
    rdy_sel = |(PREADY & psel_q);
    rd_sel  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      rd_sel = rd_sel | (PRDATA[32*i +: 32] & {32{psel_q[i]}});
    end
  end

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    penable_d = penable_q;
    psel_d    = psel_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (dec_hit) begin
            paddr_d  = addr;
            pwdata_d = wdata;
            pwrite_d = we;
            psel_d   = dec_sel;
            state_d  = SETUP;
          end else begin
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        // PREADY has priority over the timeout in the same cycle.
        if (rdy_sel) begin
          ready_d   = 1'b1;
          rdata_d   = pwrite_q ? 32'h0 : rd_sel;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          ready_d   = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '0;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      psel_q    <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      penable_q <= penable_d;
      psel_q    <= psel_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PWRITE  = pwrite_q;
  assign PENABLE = penable_q;
  assign PSEL    = psel_q;
  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign err     = err_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed bench for apb_master (4 slaves, GPIO model on
// slot 1 with registered PREADY; slots 0, 2, 3 driven directly).
module tb_apb_master;

  localparam int NUM_SLV = 4;

  logic                  PCLK = 1'b0;
  logic                  PRESET;
  logic                  req;
  logic [31:0]           addr;
  logic [31:0]           wdata;
  logic                  we;
  logic [31:0]           rdata;
  logic                  ready;
  logic                  err;
  logic [31:0]           PADDR;
  logic [31:0]           PWDATA;
  logic                  PWRITE;
  logic                  PENABLE;
  logic [NUM_SLV-1:0]    PSEL;
  logic [NUM_SLV*32-1:0] PRDATA;
  logic [NUM_SLV-1:0]    PREADY;

  logic [31:0] prd0, prd2, prd3;
  logic        rdy0, rdy2, rdy3;

  // GPIO slave: moder at offset 0 (read/write), idr at offset 4 (read only)
  logic        gpio_rdy;
  logic [31:0] gpio_moder;
  logic [31:0] gpio_idr;
  logic [31:0] gpio_rd;

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  int ready_seen;

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) begin
    if (PRESET) begin
      gpio_rdy   <= 1'b0;
      gpio_moder <= 32'h0;
    end else begin
      gpio_rdy <= PSEL[1] & PENABLE & ~gpio_rdy;
      if (PSEL[1] && PENABLE && gpio_rdy && PWRITE && PADDR[11:0] == 12'h000)
        gpio_moder <= PWDATA;
    end
  end

  assign gpio_idr = 32'h0000_00A5;
  assign gpio_rd  = (PADDR[11:0] == 12'h004) ? gpio_idr : gpio_moder;
  assign PRDATA   = {prd3, prd2, gpio_rd, prd0};
  assign PREADY   = {rdy3, rdy2, gpio_rdy, rdy0};

  apb_master #(
    .NUM_SLV    (NUM_SLV),
    .BASE_ADDR  (32'h1000_0000),
    .TIMEOUT_CYC(16)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .req    (req),
    .addr   (addr),
    .wdata  (wdata),
    .we     (we),
    .rdata  (rdata),
    .ready  (ready),
    .err    (err),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PWRITE (PWRITE),
    .PENABLE(PENABLE),
    .PSEL   (PSEL),
    .PRDATA (PRDATA),
    .PREADY (PREADY)
  );

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic w);
    req   = 1'b1;
    addr  = a;
    wdata = d;
    we    = w;
  endtask

  initial begin
    PRESET = 1'b1;
    req = 1'b0; addr = '0; wdata = '0; we = 1'b0;
    prd0 = 32'hDEAD_BEEF; prd2 = 32'h1234_5678; prd3 = 32'h3333_3333;
    rdy0 = 1'b0; rdy2 = 1'b0; rdy3 = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_psel",    32'(PSEL), 32'h0);
    chk("rst_penable", 32'(PENABLE), 32'h0);
    chk("rst_ready",   32'(ready), 32'h0);
    chk("rst_err",     32'(err), 32'h0);
    chk("rst_rdata",   rdata, 32'h0);
    chk("rst_paddr",   PADDR, 32'h0);
    PRESET = 1'b0;
    tick();

    // write GPIO moder
    issue(32'h1000_1000, 32'h0000_00FF, 1'b1);
    tick(); req = 1'b0;                                // cycle 1
    chk("wr_c1_psel",    32'(PSEL), 32'h2);
    chk("wr_c1_penable", 32'(PENABLE), 32'h0);
    chk("wr_c1_paddr",   PADDR, 32'h1000_1000);
    chk("wr_c1_pwrite",  32'(PWRITE), 32'h1);
    chk("wr_c1_pwdata",  PWDATA, 32'h0000_00FF);
    tick();                                            // cycle 2
    chk("wr_c2_psel",    32'(PSEL), 32'h2);
    chk("wr_c2_penable", 32'(PENABLE), 32'h1);
    tick();                                            // cycle 3
    chk("wr_c3_psel",    32'(PSEL), 32'h2);
    chk("wr_c3_ready",   32'(ready), 32'h0);
    tick();                                            // cycle 4
    chk("wr_c4_ready",   32'(ready), 32'h1);
    chk("wr_c4_err",     32'(err), 32'h0);
    chk("wr_c4_psel",    32'(PSEL), 32'h0);
    chk("wr_c4_penable", 32'(PENABLE), 32'h0);
    chk("wr_moder",      gpio_moder, 32'h0000_00FF);
    tick();
    chk("idle_ready",    32'(ready), 32'h0);
    chk("idle_paddr",    PADDR, 32'h1000_1000);
    chk("idle_pwdata",   PWDATA, 32'h0000_00FF);

    // read GPIO idr
    issue(32'h1000_1004, 32'h0, 1'b0);
    tick(); req = 1'b0;
    tick(); tick();                                    // cycle 3
    chk("rd_c3_ready",   32'(ready), 32'h0);
    tick();                                            // cycle 4
    chk("rd_c4_ready",   32'(ready), 32'h1);
    chk("rd_c4_rdata",   rdata, 32'h0000_00A5);
    chk("rd_c4_err",     32'(err), 32'h0);

    // back-to-back: new request in the same cycle ready is high
    issue(32'h1000_1000, 32'h0, 1'b0);
    tick(); req = 1'b0;
    chk("b2b_c1_psel",   32'(PSEL), 32'h2);
    tick(); tick(); tick();
    chk("b2b_ready",     32'(ready), 32'h1);
    chk("b2b_rdata",     rdata, 32'h0000_00FF);

    // wait states on slave 2; other slaves' PREADY high but ignored
    rdy0 = 1'b1; rdy3 = 1'b1;
    issue(32'h1000_2008, 32'h0, 1'b0);
    tick(); req = 1'b0;                                // cycle 1
    chk("ws_c1_psel",    32'(PSEL), 32'h4);
    tick(); tick(); tick(); tick();                    // cycle 5
    chk("ws_c5_psel",    32'(PSEL), 32'h4);
    chk("ws_c5_penable", 32'(PENABLE), 32'h1);
    chk("ws_c5_ready",   32'(ready), 32'h0);
    tick();                                            // cycle 6
    rdy2 = 1'b1;
    chk("ws_c6_psel",    32'(PSEL), 32'h4);
    chk("ws_c6_paddr",   PADDR, 32'h1000_2008);
    tick();                                            // cycle 7
    rdy2 = 1'b0;
    chk("ws_c7_ready",   32'(ready), 32'h1);
    chk("ws_c7_rdata",   rdata, 32'h1234_5678);
    chk("ws_c7_psel",    32'(PSEL), 32'h0);

    // decode misses: far away, one past the region, just below base
    issue(32'h2000_0000, 32'h0, 1'b0);
    tick(); req = 1'b0;
    chk("miss_ready",    32'(ready), 32'h1);
    chk("miss_err",      32'(err), 32'h1);
    chk("miss_rdata",    rdata, 32'h0);
    chk("miss_psel",     32'(PSEL), 32'h0);
    tick();
    chk("miss_c2_ready", 32'(ready), 32'h0);
    chk("miss_c2_psel",  32'(PSEL), 32'h0);
    issue(32'h1000_4000, 32'h0, 1'b1);
    tick(); req = 1'b0;
    chk("miss_top_err",  32'(err), 32'h1);
    chk("miss_top_psel", 32'(PSEL), 32'h0);
    issue(32'h0FFF_FFFC, 32'h0, 1'b0);
    tick(); req = 1'b0;
    chk("miss_low_err",  32'(err), 32'h1);
    tick();

    // last word of the region hits slave 3 (PREADY already high)
    issue(32'h1000_3FFC, 32'h0, 1'b0);
    tick(); req = 1'b0;
    chk("edge_psel",     32'(PSEL), 32'h8);
    tick(); tick();                                    // cycle 3
    chk("edge_ready",    32'(ready), 32'h1);
    chk("edge_err",      32'(err), 32'h0);
    chk("edge_rdata",    rdata, 32'h3333_3333);

    // reset in the middle of ACCESS
    rdy0 = 1'b0;
    issue(32'h1000_0010, 32'h0000_CAFE, 1'b1);
    tick(); req = 1'b0;
    tick();                                            // cycle 2
    chk("rstm_c2_penable", 32'(PENABLE), 32'h1);
    PRESET = 1'b1;
    tick();                                            // cycle 3
    PRESET = 1'b0;
    chk("rstm_psel",     32'(PSEL), 32'h0);
    chk("rstm_penable",  32'(PENABLE), 32'h0);
    chk("rstm_paddr",    PADDR, 32'h0);
    chk("rstm_pwdata",   PWDATA, 32'h0);
    chk("rstm_pwrite",   32'(PWRITE), 32'h0);
    chk("rstm_ready",    32'(ready), 32'h0);
    chk("rstm_rdata",    rdata, 32'h0);
    rdy0 = 1'b1;
    tick();
    chk("rstm_c4_ready", 32'(ready), 32'h0);
    issue(32'h1000_0000, 32'h0, 1'b0);
    tick(); req = 1'b0;
    chk("post_psel",     32'(PSEL), 32'h1);
    tick(); tick();
    chk("post_ready",    32'(ready), 32'h1);
    chk("post_rdata",    rdata, 32'hDEAD_BEEF);

    // slave 3 never answers
    rdy3 = 1'b0;
    issue(32'h1000_3000, 32'h0, 1'b0);
    tick(); req = 1'b0;
    cyc = 1;
`ifdef APB_MASTER_TIMEOUT_EN
    while (ready !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("to_cycle",      32'(cyc), 32'd18);
    chk("to_ready",      32'(ready), 32'h1);
    chk("to_err",        32'(err), 32'h1);
    chk("to_rdata",      rdata, 32'h0);
    chk("to_psel",       32'(PSEL), 32'h0);
    chk("to_penable",    32'(PENABLE), 32'h0);
`else
    ready_seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ready === 1'b1) ready_seen++;
    end
    chk("hang_ready_cnt", 32'(ready_seen), 32'd0);
    chk("hang_psel",      32'(PSEL), 32'h8);
    chk("hang_penable",   32'(PENABLE), 32'h1);
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    chk("hang_rst_psel",  32'(PSEL), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
